// File: rtl/hash_display_sequencer_if.sv
// Signal bundle between the board top level and the hash display sequencer:
// user controls, the hash core handshake, and the display word outputs.
interface hash_display_sequencer_if;
  logic         start_req;
  logic         btn_next;
  logic         btn_prev;
  logic         auto_en;
  logic         hash_done;
  logic [511:0] digest;
  logic         hash_start;
  logic         busy;
  logic         err;
  logic [4:0]   word_idx;
  logic [15:0]  word_out;

  modport master (
    output start_req, btn_next, btn_prev, auto_en, hash_done, digest,
    input  hash_start, busy, err, word_idx, word_out
  );

  modport slave (
    input  start_req, btn_next, btn_prev, auto_en, hash_done, digest,
    output hash_start, busy, err, word_idx, word_out
  );
endinterface

// File: rtl/hash_display_sequencer.sv
// Starts the SHA-512 core, waits for its digest with a timeout, then pages the
// captured 512-bit digest onto the display one 16-bit word at a time.
module hash_display_sequencer #(
  parameter int DWELL   = 125_000_000,
  parameter int TIMEOUT = 65_536
) (
  input logic                     clk,
  input logic                     rst,
  hash_display_sequencer_if.slave bus
);
  localparam int DW = $clog2(DWELL);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SHOW  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]   state_reg, state_next;
  logic [511:0] digest_reg, digest_next;
  logic [4:0]   idx_reg, idx_next;
  logic [DW-1:0] dwell_reg, dwell_next;
  logic [TW-1:0] wait_reg, wait_next;
  logic         start_prev_reg, next_prev_reg, prev_prev_reg;

  logic start_rise, next_rise, prev_rise;
  logic step_fwd, step_back;

  assign start_rise = bus.start_req & ~start_prev_reg;
  assign next_rise  = bus.btn_next  & ~next_prev_reg;
  assign prev_rise  = bus.btn_prev  & ~prev_prev_reg;
  // Simultaneous next and prev rises cancel out and count as no step.
  assign step_fwd   = next_rise & ~prev_rise;
  assign step_back  = prev_rise & ~next_rise;

  always_comb begin
    state_next  = state_reg;
    digest_next = digest_reg;
    idx_next    = idx_reg;
    dwell_next  = dwell_reg;
    wait_next   = wait_reg;
    case (state_reg)
      S_IDLE: begin
        if (start_rise) state_next = S_START;
      end
      S_START: begin
        wait_next  = '0;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the last allowed cycle still wins over timeout.
        if (bus.hash_done) begin
          state_next  = S_SHOW;
          digest_next = bus.digest;
          idx_next    = '0;
          dwell_next  = '0;
        end else if (wait_reg == TW'(TIMEOUT - 1)) begin
          state_next = S_ERR;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end
      S_SHOW: begin
        if (start_rise) begin
          state_next = S_START;
          dwell_next = '0;
        end else if (step_fwd) begin
          idx_next   = idx_reg + 1'b1;
          dwell_next = '0;
        end else if (step_back) begin
          idx_next   = idx_reg - 1'b1;
          dwell_next = '0;
        end else if (!bus.auto_en) begin
          dwell_next = '0;
        end else if (dwell_reg == DW'(DWELL - 1)) begin
          idx_next   = idx_reg + 1'b1;
          dwell_next = '0;
        end else begin
          dwell_next = dwell_reg + 1'b1;
        end
      end
      S_ERR: begin
        if (start_rise) state_next = S_START;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_IDLE;
      digest_reg     <= '0;
      idx_reg        <= '0;
      dwell_reg      <= '0;
      wait_reg       <= '0;
      start_prev_reg <= 1'b0;
      next_prev_reg  <= 1'b0;
      prev_prev_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      digest_reg     <= digest_next;
      idx_reg        <= idx_next;
      dwell_reg      <= dwell_next;
      wait_reg       <= wait_next;
      start_prev_reg <= bus.start_req;
      next_prev_reg  <= bus.btn_next;
      prev_prev_reg  <= bus.btn_prev;
    end
  end

  logic [15:0] words [32];

  for (genvar gi = 0; gi < 32; gi++) begin : g_words
    assign words[gi] = digest_reg[16*gi +: 16];
  end

  assign bus.hash_start = (state_reg == S_START);
  assign bus.busy       = (state_reg == S_START) || (state_reg == S_WAIT);
  assign bus.err        = (state_reg == S_ERR);
  assign bus.word_idx   = idx_reg;
  assign bus.word_out   = (state_reg == S_ERR) ? 16'hEEEE : words[idx_reg];
endmodule

// File: tb/tb_hash_display_sequencer.sv
// Directed bench for hash_display_sequencer: run/capture, manual and auto paging,
// timeout error and asynchronous reset abort.
module tb_hash_display_sequencer;
  localparam int DWELL   = 4;
  localparam int TIMEOUT = 16;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  hash_display_sequencer_if bus ();

  hash_display_sequencer #(.DWELL(DWELL), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] exp_word(input int i);
    if (i == 0)  return 16'h2baf;
    if (i == 31) return 16'hd693;
    return 16'h5a00 | 16'(i);
  endfunction

  function automatic logic [511:0] make_digest();
    logic [511:0] d;
    for (int i = 0; i < 32; i++) d[16*i +: 16] = exp_word(i);
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_next();
    bus.btn_next = 1'b1; tick();
    bus.btn_next = 1'b0; tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start_req = 0; bus.btn_next = 0; bus.btn_prev = 0; bus.auto_en = 0;
    bus.hash_done = 0; bus.digest = '0;
    #12;
    tests_run++;
    if ({bus.hash_start, bus.busy, bus.err} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_flags got %b want 000", {bus.hash_start, bus.busy, bus.err});
    end
    tests_run++;
    if (bus.word_idx !== 5'd0 || bus.word_out !== 16'h0000) begin
      tests_failed++; $display("FAIL reset_word got idx=%0d word=%h want idx=0 word=0000", bus.word_idx, bus.word_out);
    end
    rst = 1'b1;
    tick();
    $display("[TB] reset done");
  endtask

  task automatic test_run();
    int hs, bsy;
    hs = 0; bsy = 0;
    bus.start_req = 1'b1; tick();
    tests_run++;
    if (bus.hash_start !== 1'b1 || bus.busy !== 1'b1) begin
      tests_failed++; $display("FAIL start_state got hs=%b busy=%b want 1 1", bus.hash_start, bus.busy);
    end
    if (bus.hash_start) hs++;
    if (bus.busy) bsy++;
    bus.start_req = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (bus.hash_start) hs++;
      if (bus.busy) bsy++;
      if (k == 10) begin bus.hash_done = 1'b1; bus.digest = make_digest(); end
    end
    tick();
    bus.hash_done = 1'b0; bus.digest = '1;
    if (bus.busy) bsy++;
    tests_run++;
    if (hs !== 1) begin tests_failed++; $display("FAIL hash_start_cycles got %0d want 1", hs); end
    tests_run++;
    if (bsy !== 11) begin tests_failed++; $display("FAIL busy_cycles got %0d want 11", bsy); end
    tests_run++;
    if (bus.word_idx !== 5'd0 || bus.word_out !== 16'h2baf) begin
      tests_failed++; $display("FAIL capture got idx=%0d word=%h want idx=0 word=2baf", bus.word_idx, bus.word_out);
    end
    $display("[TB] run: hash_start=%0d busy=%0d word=%h", hs, bsy, bus.word_out);
  endtask

  task automatic test_manual();
    bus.btn_prev = 1'b1; tick();
    tests_run++;
    if (bus.word_idx !== 5'd31 || bus.word_out !== 16'hd693) begin
      tests_failed++; $display("FAIL prev_wrap got idx=%0d word=%h want idx=31 word=d693", bus.word_idx, bus.word_out);
    end
    bus.btn_prev = 1'b0; tick();
    bus.btn_next = 1'b1; tick();
    tests_run++;
    if (bus.word_idx !== 5'd0) begin
      tests_failed++; $display("FAIL next_wrap got idx=%0d want 0", bus.word_idx);
    end
    bus.btn_next = 1'b0; tick();
    press_next();
    tests_run++;
    if (bus.word_idx !== 5'd1 || bus.word_out !== exp_word(1)) begin
      tests_failed++; $display("FAIL next_step got idx=%0d word=%h want idx=1 word=%h", bus.word_idx, bus.word_out, exp_word(1));
    end
    $display("[TB] manual: idx=%0d word=%h", bus.word_idx, bus.word_out);
  endtask

  task automatic test_simultaneous();
    bus.btn_next = 1'b1; bus.btn_prev = 1'b1; tick();
    tests_run++;
    if (bus.word_idx !== 5'd1) begin
      tests_failed++; $display("FAIL both_buttons got idx=%0d want 1", bus.word_idx);
    end
    bus.btn_next = 1'b0; bus.btn_prev = 1'b0; tick();
    $display("[TB] simultaneous: idx=%0d", bus.word_idx);
  endtask

  task automatic test_hold();
    bus.btn_next = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    tests_run++;
    if (bus.word_idx !== 5'd2) begin
      tests_failed++; $display("FAIL hold_next got idx=%0d want 2", bus.word_idx);
    end
    bus.btn_next = 1'b0; tick();
    $display("[TB] hold: idx=%0d", bus.word_idx);
  endtask

  task automatic test_auto();
    for (int k = 0; k < 28; k++) press_next();
    tests_run++;
    if (bus.word_idx !== 5'd30) begin
      tests_failed++; $display("FAIL auto_setup got idx=%0d want 30", bus.word_idx);
    end
    bus.auto_en = 1'b1;
    tick(); tick(); tick();
    tests_run++;
    if (bus.word_idx !== 5'd30) begin
      tests_failed++; $display("FAIL auto_early got idx=%0d want 30", bus.word_idx);
    end
    tick();
    tests_run++;
    if (bus.word_idx !== 5'd31 || bus.word_out !== 16'hd693) begin
      tests_failed++; $display("FAIL auto_step1 got idx=%0d word=%h want idx=31 word=d693", bus.word_idx, bus.word_out);
    end
    tick(); tick(); tick();
    tests_run++;
    if (bus.word_idx !== 5'd31) begin
      tests_failed++; $display("FAIL auto_hold got idx=%0d want 31", bus.word_idx);
    end
    tick();
    tests_run++;
    if (bus.word_idx !== 5'd0) begin
      tests_failed++; $display("FAIL auto_wrap got idx=%0d want 0", bus.word_idx);
    end
    tick(); tick(); tick();
    bus.btn_next = 1'b1; tick();
    tests_run++;
    if (bus.word_idx !== 5'd1) begin
      tests_failed++; $display("FAIL coincident got idx=%0d want 1", bus.word_idx);
    end
    bus.btn_next = 1'b0; tick(); tick(); tick();
    tests_run++;
    if (bus.word_idx !== 5'd1) begin
      tests_failed++; $display("FAIL dwell_restart got idx=%0d want 1", bus.word_idx);
    end
    tick();
    tests_run++;
    if (bus.word_idx !== 5'd2) begin
      tests_failed++; $display("FAIL auto_after_manual got idx=%0d want 2", bus.word_idx);
    end
    bus.auto_en = 1'b0; tick();
    $display("[TB] auto: idx=%0d", bus.word_idx);
  endtask

  task automatic test_timeout();
    bus.start_req = 1'b1; tick();
    tests_run++;
    if (bus.hash_start !== 1'b1 || bus.word_idx !== 5'd2) begin
      tests_failed++; $display("FAIL restart got hs=%b idx=%0d want hs=1 idx=2", bus.hash_start, bus.word_idx);
    end
    bus.start_req = 1'b0; tick();
    for (int k = 0; k < TIMEOUT - 1; k++) tick();
    tests_run++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
      tests_failed++; $display("FAIL timeout_early got err=%b busy=%b want 0 1", bus.err, bus.busy);
    end
    tick();
    tests_run++;
    if (bus.err !== 1'b1 || bus.word_out !== 16'hEEEE || bus.busy !== 1'b0) begin
      tests_failed++; $display("FAIL timeout got err=%b word=%h busy=%b want 1 EEEE 0", bus.err, bus.word_out, bus.busy);
    end
    tick();
    bus.start_req = 1'b1; tick();
    tests_run++;
    if (bus.err !== 1'b0 || bus.hash_start !== 1'b1) begin
      tests_failed++; $display("FAIL err_restart got err=%b hs=%b want 0 1", bus.err, bus.hash_start);
    end
    bus.start_req = 1'b0; tick();
    $display("[TB] timeout: recovered to WAIT busy=%b", bus.busy);
  endtask

  task automatic test_async_reset();
    tick(); tick();
    rst = 1'b0;
    #1;
    tests_run++;
    if ({bus.hash_start, bus.busy, bus.err} !== 3'b000 || bus.word_idx !== 5'd0 || bus.word_out !== 16'h0000) begin
      tests_failed++; $display("FAIL async_reset got flags=%b idx=%0d word=%h want 000 0 0000",
        {bus.hash_start, bus.busy, bus.err}, bus.word_idx, bus.word_out);
    end
    #2;
    rst = 1'b1;
    tick();
    bus.hash_done = 1'b1; bus.digest = make_digest(); tick();
    bus.hash_done = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.word_out !== 16'h0000 || bus.word_idx !== 5'd0) begin
      tests_failed++; $display("FAIL idle_done got busy=%b idx=%0d word=%h want 0 0 0000", bus.busy, bus.word_idx, bus.word_out);
    end
    bus.btn_next = 1'b1; tick();
    tests_run++;
    if (bus.word_idx !== 5'd0) begin
      tests_failed++; $display("FAIL idle_button got idx=%0d want 0", bus.word_idx);
    end
    bus.btn_next = 1'b0; tick();
    $display("[TB] async reset: word=%h", bus.word_out);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_run();
    test_manual();
    test_simultaneous();
    test_hold();
    test_auto();
    test_timeout();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
